// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared widths, FSM encoding and field slicers for the fpcvt 8-bit float format
package fpcvt_pkg;
  localparam int DEF_EXP_W = 3;
  localparam int DEF_SIG_W = 4;
  localparam int DEF_LIN_W = 12;
  localparam int DEF_FP_W = 1 + DEF_EXP_W + DEF_SIG_W;
  typedef logic [DEF_FP_W-1:0] fp_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    NEG   = 2'd2,
    DONE  = 2'd3
  } state_t;
  function automatic logic fp_sign(input fp_t fp);
    return fp[DEF_FP_W-1];
  endfunction
  function automatic logic [DEF_EXP_W-1:0] fp_exp(input fp_t fp);
    return fp[DEF_SIG_W+:DEF_EXP_W];
  endfunction
  function automatic logic [DEF_SIG_W-1:0] fp_sig(input fp_t fp);
    return fp[DEF_SIG_W-1:0];
  endfunction
endpackage

// File: rtl/fp_to_linear.sv
// fp_to_linear: expands an fpcvt code to a two's-complement linear value, one shift per cycle
module fp_to_linear
  import fpcvt_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int SIG_W = DEF_SIG_W,
  parameter int LIN_W = DEF_LIN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+SIG_W:0]   in_fp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LIN_W-1:0]       out_lin,
  output logic                   busy
);
  localparam int MAG_W = LIN_W - 1;
  if (LIN_W < SIG_W + 2**EXP_W) begin : g_width_check
    $error("fp_to_linear: LIN_W too narrow for largest shifted significand");
  end
  state_t state, state_next;
  logic [MAG_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic             sign;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt == '0) state_next = NEG;
      NEG:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mag     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      out_lin <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        sign <= in_fp[EXP_W+SIG_W];
        cnt  <= in_fp[SIG_W+:EXP_W];
        mag  <= {{(MAG_W-SIG_W){1'b0}}, in_fp[SIG_W-1:0]};
      end
      if (state == SHIFT && cnt != '0) begin
        mag <= mag << 1;
        cnt <= cnt - 1'b1;
      end
      // negative zero naturally collapses: -0 == 0 in two's complement
      if (state == NEG) out_lin <= sign ? -{1'b0, mag} : {1'b0, mag};
    end
  end
endmodule

// File: tb/tb_fp_to_linear.sv
// tb_fp_to_linear: directed vectors with hand-computed results for the fpcvt decoder
module tb_fp_to_linear;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_fp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_lin;
  logic        busy;
  int checks = 0;
  int errors = 0;

  fp_to_linear dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
    .out_valid(out_valid), .out_ready(out_ready), .out_lin(out_lin), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_code(input string tag, input logic [7:0] code, input logic [11:0] lin, input int lat);
    int n;
    chk({tag, "_idle_ready"}, in_ready, 1);
    in_fp = code;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_lin"}, out_lin, lin);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_lin", out_lin, 0);
    chk("rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    run_code("pmax", 8'h7F, 12'h780, 9);
    run_code("nmax", 8'hFF, 12'h880, 9);
    run_code("n80", 8'hBA, 12'hFB0, 5);
    run_code("p5", 8'h05, 12'h005, 2);
    run_code("nzero", 8'h80, 12'h000, 2);
    // backpressure: hold the sink off for five cycles
    out_ready = 1'b0;
    in_fp = 8'h23;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_lin_hold", out_lin, 12'h00C);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    // back-to-back with in_valid held through both codes
    in_fp = 8'h15;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_fp = 8'hA2;
    wait_valid(n);
    chk("b2b_a_latency", n, 3);
    chk("b2b_a_lin", out_lin, 12'h00A);
    @(posedge clk); #1;
    chk("b2b_handshake_valid", out_valid, 0);
    chk("b2b_handshake_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_b_accepted", busy, 1);
    wait_valid(n);
    chk("b2b_b_latency", n, 4);
    chk("b2b_b_lin", out_lin, 12'hFF8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_no_dup_busy", busy, 0);
    chk("b2b_no_dup_valid", out_valid, 0);
    // reset in the middle of a shift
    in_fp = 8'h69;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_lin", out_lin, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    #12 rst_n = 1'b1;
    run_code("post_rst", 8'h11, 12'h002, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_to_linear.md
Name: fp_to_linear

Overview:
Sequential decoder for the fpcvt 8-bit floating-point format (sign, 3-bit exponent, 4-bit significand). It expands each code back to a 12-bit two's-complement linear value: value = ±(significand << exponent). It is the inverse path to the linear-to-FP converter and rounder. It sits behind a valid/ready source and drives a valid/ready sink, shifting one bit per cycle.

Parameters:
EXP_W, 3, exponent field width
SIG_W, 4, significand field width
LIN_W, 12, linear output width; must be >= SIG_W + 2**EXP_W (checked at elaboration; simulation error if violated)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_fp is valid
in_ready  output  1  block can accept a code
in_fp  input  1+EXP_W+SIG_W  {sign, exp, sig}, sign is MSB
out_valid  output  1  out_lin is valid
out_ready  input  1  sink accepts out_lin
out_lin  output  LIN_W  two's-complement linear result
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_lin=0, busy=0, internal mag/cnt/sign=0.
- FSM states: IDLE, SHIFT, NEG, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid&&in_ready: latch sign, cnt=exp, mag=zero-extended sig (LIN_W-1 bits). Go to SHIFT.
- SHIFT: in_ready=0.
  - If cnt!=0: mag<=mag<<1, cnt<=cnt-1.
  - If cnt==0: go to NEG.
  - SHIFT therefore occupies exp+1 cycles.
- NEG: compute out_lin = sign ? -{1'b0,mag} : {1'b0,mag}, registered. Go to DONE.
  - A negative zero (sign=1, sig=0) yields 0.
- DONE: out_valid=1; out_lin stays stable while out_ready=0.
  - On an edge with out_ready=1: out_valid falls and the FSM goes to IDLE. out_lin keeps its last value; it is don't-care when out_valid=0.
- Latency: out_valid rises exp+2 edges after the accept edge. The range is 2 (exp=0) to 9 (exp=7) edges.
- Throughput: one code per exp+4 cycles minimum. There is no input/output overlap; in_ready=0 in SHIFT, NEG and DONE.
- Width rule: the maximum magnitude is 15<<7 = 1920, so no overflow is possible with defaults. Negation is plain two's complement; no saturation.
- in_fp changes while not in IDLE are ignored.
- in_valid held high in DONE is not consumed until after return to IDLE (earliest accept is one edge after the out handshake).
- out_ready high outside DONE has no effect.
- Reset asserted mid-operation (any state) immediately forces the reset values; the in-flight code is dropped. First accept is possible on the first edge after rst_n rises.

Decomposition:
- Shared package/include fpcvt_pkg: EXP_W, SIG_W and LIN_W defaults; state encoding constants (IDLE=0, SHIFT=1, NEG=2, DONE=3); field-slice helpers for sign/exp/sig. The existing encoder and rounder reuse these.
- No sub-module. Shifter, counter and negator are small enough to live inline.

Test Plan:
- in_fp=0_111_1111, out_ready=1 -> out_lin=0x780 (1920); out_valid 9 edges after accept, high for 1 cycle.
- in_fp=1_111_1111 -> out_lin=0x880 (-1920); in_fp=1_011_1010 -> out_lin=0xFB0 (-80), latency 5.
- in_fp=0_000_0101 -> out_lin=0x005, latency 2; in_fp=1_000_0000 -> out_lin=0x000 (negative zero collapses).
- Backpressure: 0_010_0011 with out_ready=0 for 5 cycles -> out_valid and out_lin=0x00C held stable, in_ready=0, busy=1. On out_ready=1, one edge later in_ready=1.
- Back-to-back with in_valid held high through two codes -> second accepted exactly one edge after the first out handshake; no code lost or duplicated.
- rst_n low during SHIFT of 0_110_1001 -> out_valid=0, out_lin=0, in_ready=1 immediately. After release, new code 0_001_0001 -> 0x002, no residue from the aborted one.
